fifo_control: RTL

Pointer and flag controller for the dual-pointer FIFO memory in the transmission-layer datapath. It turns requester push/pop strobes into memory wr_enable/rd_enable plus wr_ptr/rd_ptr. It tracks occupancy and drives full, empty and programmable almost-full/almost-empty flags for upstream flow control. It also raises sticky overflow/underflow errors and a read-data-valid strobe aligned to the memory's registered read output.

---
 rtl/fifo_control.sv | 84 ++++++++
 1 files changed

// File: rtl/fifo_control.sv
// rtl/fifo_control.sv - pointer, occupancy and flag controller for a dual-pointer FIFO memory
module fifo_control #(
  parameter int address_width = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [address_width-1:0] almost_full_thr,
  input  logic [address_width-1:0] almost_empty_thr,
  output logic                     wr_enable,
  output logic                     rd_enable,
  output logic [address_width-1:0] wr_ptr,
  output logic [address_width-1:0] rd_ptr,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [address_width:0]   occupancy,
  output logic                     rd_valid,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  // Occupancy value meaning "every slot holds a word" (DEPTH = 2**address_width).
  localparam logic [address_width:0] depth_count = {1'b1, {address_width{1'b0}}};

  logic wr_acc;
  logic rd_acc;

  // Flag decode and request acceptance; strobes are held off while reset is asserted.
  always_comb begin
    full         = (occupancy == depth_count);
    empty        = (occupancy == '0);
    almost_full  = (occupancy >= {1'b0, almost_full_thr});
    almost_empty = (occupancy <= {1'b0, almost_empty_thr});
    wr_acc       = push & ~full & ~reset;
    rd_acc       = pop & ~empty & ~reset;
    wr_enable    = wr_acc;
    rd_enable    = rd_acc;
  end

  // Pointers wrap naturally at DEPTH because they are exactly address_width bits wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Stored word count; simultaneous accepted push and pop cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Read data from the memory is registered, so valid trails the accepted pop by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_valid <= 1'b0;
    else       rd_valid <= rd_acc;
  end

  // Sticky protocol errors: request seen against a full or empty FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push & full) overflow_err  <= 1'b1;
      if (pop & empty) underflow_err <= 1'b1;
    end
  end

endmodule
